// File: rtl/operand2_shifter_pipe.sv
// Two-stage ARM operand-2 generator: S1 decodes mode/amount/carry source, S2 shifts and registers.
// Covers immediate rotate, immediate/register shifts, RRX and memory offsets with valid/ready flow.
module operand2_shifter_pipe #(
    parameter int DATA_W         = 32,
    parameter bit MEM_OFF_SIGNED = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] reg2_val,
    input  logic [7:0]        rs_val,
    input  logic [11:0]       shift_operand,
    input  logic              immediate,
    input  logic              mem_enable,
    input  logic              carry_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_in2_val,
    output logic              shifter_cout
);

    localparam int         AW = $clog2(DATA_W);
    localparam logic [7:0] N8 = 8'(DATA_W);

    typedef enum logic [2:0] {
        MODE_PASS,
        MODE_IMM,
        MODE_RRX,
        MODE_LSL,
        MODE_LSR,
        MODE_ASR,
        MODE_ROR
    } mode_t;

    logic              s1_valid, s2_valid, s2_load;
    mode_t             s1_mode, d_mode;
    logic [DATA_W-1:0] s1_data, d_data, mem_off;
    logic [7:0]        s1_amt, d_amt;
    logic              s1_cin;

    assign s2_load   = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s2_load;
    assign out_valid = s2_valid;

    always_comb begin
        mem_off = MEM_OFF_SIGNED ? {{(DATA_W-12){shift_operand[11]}}, shift_operand}
                                 : {{(DATA_W-12){1'b0}}, shift_operand};
    end

    always_comb begin
        d_mode = MODE_PASS;
        d_data = reg2_val;
        d_amt  = '0;
        if (mem_enable) begin
            d_data = mem_off;
        end else if (immediate) begin
            d_mode = MODE_IMM;
            d_data = DATA_W'(shift_operand[7:0]);
            d_amt  = {3'b000, shift_operand[11:8], 1'b0} & (N8 - 8'd1);
        end else begin
            d_amt = shift_operand[4] ? rs_val : {3'b000, shift_operand[11:7]};
            case (shift_operand[6:5])
                2'b00:   d_mode = MODE_LSL;
                2'b01:   d_mode = MODE_LSR;
                2'b10:   d_mode = MODE_ASR;
                default: d_mode = MODE_ROR;
            endcase
            // Immediate shift by zero re-encodes LSR/ASR as a full-width shift and ROR as RRX
            if (!shift_operand[4] && shift_operand[11:7] == 5'd0) begin
                case (shift_operand[6:5])
                    2'b01, 2'b10: d_amt  = N8;
                    2'b11:        d_mode = MODE_RRX;
                    default:      ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_mode  <= MODE_PASS;
            s1_data  <= '0;
            s1_amt   <= '0;
            s1_cin   <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_mode <= d_mode;
                s1_data <= d_data;
                s1_amt  <= d_amt;
                s1_cin  <= carry_in;
            end
        end
    end

    logic [DATA_W:0]   lsl_full, lsr_full, asr_full;
    logic [DATA_W-1:0] ror_res, res;
    logic [AW-1:0]     rot;
    logic [AW:0]       rot_back;
    logic [7:0]        asr_amt;
    logic              cout;

    // Extra bit below/above the operand captures the last bit shifted out, covering amt==N and amt>N
    always_comb begin
        lsl_full = {1'b0, s1_data} << s1_amt;
        lsr_full = {s1_data, 1'b0} >> s1_amt;
        asr_amt  = (s1_amt > N8) ? N8 : s1_amt;
        asr_full = $signed({s1_data, 1'b0}) >>> asr_amt;
        rot      = s1_amt[AW-1:0];
        rot_back = (AW+1)'(DATA_W) - {1'b0, rot};
        ror_res  = (s1_data >> rot) | (s1_data << rot_back);
        res      = s1_data;
        cout     = s1_cin;
        case (s1_mode)
            MODE_IMM: begin
                res = ror_res;
                if (rot != '0) cout = ror_res[DATA_W-1];
            end
            MODE_RRX: begin
                res  = {s1_cin, s1_data[DATA_W-1:1]};
                cout = s1_data[0];
            end
            MODE_LSL: if (s1_amt != '0) {cout, res} = lsl_full;
            MODE_LSR: if (s1_amt != '0) {res, cout} = lsr_full;
            MODE_ASR: if (s1_amt != '0) {res, cout} = asr_full;
            MODE_ROR: if (s1_amt != '0) begin
                res  = ror_res;
                cout = ror_res[DATA_W-1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid     <= 1'b0;
            alu_in2_val  <= '0;
            shifter_cout <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                alu_in2_val  <= res;
                shifter_cout <= cout;
            end
        end
    end

endmodule

// File: tb/tb_operand2_shifter_pipe.sv
// Scoreboard bench for operand2_shifter_pipe: a 32-bit signed-offset and a 16-bit unsigned-offset
// instance share stimulus; expectations are queued at accept and popped by per-instance monitors.
module tb_operand2_shifter_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, out_ready, immediate, mem_enable, carry_in;
    logic [31:0] reg2_val;
    logic [7:0]  rs_val;
    logic [11:0] shift_operand;

    logic        in_ready32, out_valid32, cout32;
    logic [31:0] alu32;
    logic        in_ready16, out_valid16, cout16;
    logic [15:0] alu16;

    operand2_shifter_pipe #(.DATA_W(32), .MEM_OFF_SIGNED(1'b1)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
        .reg2_val(reg2_val), .rs_val(rs_val), .shift_operand(shift_operand),
        .immediate(immediate), .mem_enable(mem_enable), .carry_in(carry_in),
        .out_valid(out_valid32), .out_ready(out_ready),
        .alu_in2_val(alu32), .shifter_cout(cout32)
    );

    operand2_shifter_pipe #(.DATA_W(16), .MEM_OFF_SIGNED(1'b0)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16),
        .reg2_val(reg2_val[15:0]), .rs_val(rs_val), .shift_operand(shift_operand),
        .immediate(immediate), .mem_enable(mem_enable), .carry_in(carry_in),
        .out_valid(out_valid16), .out_ready(out_ready),
        .alu_in2_val(alu16), .shifter_cout(cout16)
    );

    int checks = 0;
    int errors = 0;
    logic [32:0] q32[$];
    logic [16:0] q16[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Bit-by-bit reference: returns {cout, value} for an n-bit operand
    function automatic logic [64:0] model(input int n, input bit msigned, input logic [63:0] rm_in,
                                          input logic [7:0] rs, input logic [11:0] so,
                                          input logic imm, input logic mem, input logic cin);
        logic [63:0] rm, res, src;
        logic c;
        int amt, r;
        rm = rm_in;
        for (int i = n; i < 64; i++) rm[i] = 1'b0;
        res = '0;
        src = '0;
        c = cin;
        if (mem) begin
            for (int i = 0; i < n; i++) begin
                if (i < 12) res[i] = so[i];
                else        res[i] = msigned ? so[11] : 1'b0;
            end
        end else if (imm) begin
            src[7:0] = so[7:0];
            r = (2 * int'(so[11:8])) % n;
            for (int i = 0; i < n; i++) res[i] = src[(i + r) % n];
            if (r != 0) c = res[n-1];
        end else begin
            amt = so[4] ? int'(rs) : int'(so[11:7]);
            if (!so[4] && amt == 0 && so[6:5] == 2'b11) begin
                res[n-1] = cin;
                for (int i = 0; i < n - 1; i++) res[i] = rm[i+1];
                return {rm[0], res};
            end
            if (!so[4] && amt == 0 && (so[6:5] == 2'b01 || so[6:5] == 2'b10)) amt = n;
            if (amt == 0) begin
                res = rm;
            end else begin
                case (so[6:5])
                    2'b00: begin
                        for (int i = 0; i < n; i++) if (i >= amt) res[i] = rm[i-amt];
                        c = (amt <= n) ? rm[n-amt] : 1'b0;
                    end
                    2'b01: begin
                        for (int i = 0; i < n; i++) if (i + amt < n) res[i] = rm[i+amt];
                        c = (amt <= n) ? rm[amt-1] : 1'b0;
                    end
                    2'b10: begin
                        for (int i = 0; i < n; i++) begin
                            if (i + amt < n) res[i] = rm[i+amt];
                            else             res[i] = rm[n-1];
                        end
                        c = (amt <= n) ? rm[amt-1] : rm[n-1];
                    end
                    default: begin
                        r = amt % n;
                        for (int i = 0; i < n; i++) res[i] = rm[(i + r) % n];
                        c = (r == 0) ? rm[n-1] : rm[r-1];
                    end
                endcase
            end
        end
        return {c, res};
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input logic [31:0] rm, input logic [7:0] rs, input logic [11:0] so,
                        input logic imm, input logic mem, input logic cin,
                        input bit hand, input logic [32:0] hexp);
        int waited;
        logic [64:0] m;
        reg2_val = rm; rs_val = rs; shift_operand = so;
        immediate = imm; mem_enable = mem; carry_in = cin; in_valid = 1'b1;
        #1;
        waited = 0;
        while (!(in_ready32 && in_ready16) && waited < 50) begin
            @(posedge clk); #2;
            waited++;
        end
        if (waited >= 50) begin
            chk("accept_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
            @(posedge clk); #1;
            return;
        end
        if (hand) q32.push_back(hexp);
        else begin
            m = model(32, 1'b1, {32'b0, rm}, rs, so, imm, mem, cin);
            q32.push_back({m[64], m[31:0]});
        end
        m = model(16, 1'b0, {32'b0, rm}, rs, so, imm, mem, cin);
        q16.push_back({m[64], m[15:0]});
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic dv(input logic [31:0] rm, input logic [7:0] rs, input logic [11:0] so,
                      input logic imm, input logic mem, input logic cin,
                      input logic ecout, input logic [31:0] ealu);
        send(rm, rs, so, imm, mem, cin, 1'b1, {ecout, ealu});
    endtask

    task automatic latency_check(input string tag);
        @(negedge clk);
        chk({tag, "_cycle1_valid"}, 64'(out_valid32), 64'd0);
        @(negedge clk);
        chk({tag, "_cycle2_valid"}, 64'(out_valid32), 64'd1);
        @(posedge clk); #1;
    endtask

    logic        held32, held16;
    logic [32:0] hv32;
    logic [16:0] hv16;

    always @(negedge clk) begin
        if (rst) begin
            held32 <= 1'b0;
        end else begin
            if (held32 && out_valid32) chk("hold32", 64'({cout32, alu32}), 64'(hv32));
            if (out_valid32 && out_ready) begin
                if (q32.size() == 0) chk("spurious32", 64'd1, 64'd0);
                else chk("out32", 64'({cout32, alu32}), 64'(q32.pop_front()));
            end
            held32 <= out_valid32 && !out_ready;
            hv32   <= {cout32, alu32};
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            held16 <= 1'b0;
        end else begin
            if (held16 && out_valid16) chk("hold16", 64'({cout16, alu16}), 64'(hv16));
            if (out_valid16 && out_ready) begin
                if (q16.size() == 0) chk("spurious16", 64'd1, 64'd0);
                else chk("out16", 64'({cout16, alu16}), 64'(q16.pop_front()));
            end
            held16 <= out_valid16 && !out_ready;
            hv16   <= {cout16, alu16};
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    bit done;
    logic [7:0] rs_list [12] = '{8'd0, 8'd1, 8'd7, 8'd8, 8'd15, 8'd16, 8'd17, 8'd31, 8'd32, 8'd33, 8'd64, 8'd255};

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        reg2_val = '0; rs_val = '0; shift_operand = '0;
        immediate = 1'b0; mem_enable = 1'b0; carry_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", 64'(out_valid32), 64'd0);
        chk("reset_alu", 64'(alu32), 64'd0);
        chk("reset_cout", 64'(cout32), 64'd0);
        chk("reset_in_ready", 64'(in_ready32), 64'd1);
        chk("reset_out_valid16", 64'(out_valid16), 64'd0);
        @(posedge clk); #1;

        // Immediate rotate with two-cycle latency
        dv(32'h0, 8'd0, 12'h4FF, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFF000000);
        latency_check("imm");

        // Directed back-to-back vectors
        dv(32'h80000001, 8'd32,  12'h010, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00000000);
        dv(32'h80000001, 8'd33,  12'h010, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000);
        dv(32'h80000001, 8'd0,   12'h010, 1'b0, 1'b0, 1'b1, 1'b1, 32'h80000001);
        dv(32'h00000003, 8'd0,   12'h060, 1'b0, 1'b0, 1'b1, 1'b1, 32'h80000001);
        dv(32'h80000000, 8'd0,   12'h040, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF);
        dv(32'h00000000, 8'd0,   12'hFFC, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFC);
        dv(32'h000000F8, 8'd4,   12'h030, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000000F);
        dv(32'h12345678, 8'd8,   12'h070, 1'b0, 1'b0, 1'b1, 1'b0, 32'h78123456);
        dv(32'h12345678, 8'd32,  12'h070, 1'b0, 1'b0, 1'b1, 1'b0, 32'h12345678);
        dv(32'hF000000F, 8'd0,   12'h200, 1'b0, 1'b0, 1'b0, 1'b1, 32'h000000F0);
        dv(32'h80000000, 8'd0,   12'h020, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00000000);
        dv(32'h7FFFFFFF, 8'd40,  12'h050, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00000000);
        dv(32'h00000000, 8'd0,   12'h000, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00000000);
        dv(32'h00000000, 8'd0,   12'h1FF, 1'b1, 1'b0, 1'b0, 1'b1, 32'hC000003F);
        dv(32'h00000000, 8'd0,   12'h123, 1'b1, 1'b1, 1'b1, 1'b1, 32'h00000123);
        dv(32'hFFFFFFFF, 8'd255, 12'h010, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00000000);
        dv(32'h80000000, 8'd32,  12'h030, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00000000);

        // Backpressure: consumer stalls while four requests arrive back to back
        out_ready = 1'b0;
        fork
            begin
                dv(32'h0, 8'd0, 12'h0A1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h000000A1);
                dv(32'h0, 8'd0, 12'h0A2, 1'b1, 1'b0, 1'b0, 1'b0, 32'h000000A2);
                dv(32'h0, 8'd0, 12'h0A3, 1'b1, 1'b0, 1'b0, 1'b0, 32'h000000A3);
                dv(32'h0, 8'd0, 12'h0A4, 1'b1, 1'b0, 1'b0, 1'b0, 32'h000000A4);
            end
            begin
                @(posedge clk);
                @(posedge clk); #2;
                chk("bp_in_ready_low", 64'(in_ready32), 64'd0);
                chk("bp_out_valid", 64'(out_valid32), 64'd1);
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join

        // Reset with two entries in flight
        repeat (8) @(posedge clk);
        #1 out_ready = 1'b0;
        dv(32'h11111111, 8'd1, 12'h010, 1'b0, 1'b0, 1'b0, 1'b0, 32'h22222222);
        dv(32'h22222222, 8'd1, 12'h010, 1'b0, 1'b0, 1'b0, 1'b0, 32'h44444444);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q32.delete();
        q16.delete();
        @(negedge clk);
        chk("flush_out_valid", 64'(out_valid32), 64'd0);
        chk("flush_alu", 64'(alu32), 64'd0);
        chk("flush_cout", 64'(cout32), 64'd0);
        chk("flush_out_valid16", 64'(out_valid16), 64'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        dv(32'h00000001, 8'd31, 12'h010, 1'b0, 1'b0, 1'b0, 1'b0, 32'h80000000);
        latency_check("post_reset");

        // Random traffic against the reference model with random consumer stalls
        done = 1'b0;
        fork
            begin
                for (int k = 0; k < 300; k++) begin
                    send($urandom,
                         ($urandom_range(0, 1) == 1) ? rs_list[$urandom_range(0, 11)] : 8'($urandom),
                         12'($urandom),
                         ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                         1'($urandom), 1'b0, '0);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;

        for (int w = 0; w < 100 && (q32.size() != 0 || q16.size() != 0); w++) @(posedge clk);
        @(negedge clk);
        chk("drain32", 64'(q32.size()), 64'd0);
        chk("drain16", 64'(q16.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
